// File: rtl/pb_field_sequencer.sv
// Protobuf field sequencer: latches a field request, samples the header/varint
// encoders for one cycle, then streams header and value bytes on an 8-bit valid/ready port.
module pb_field_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [28:0]       req_field_id,
  input  logic [4:0]        req_field_type,
  input  logic [63:0]       req_value,
  input  logic              req_last,
  output logic [28:0]       enc_field_id,
  output logic [4:0]        enc_field_type,
  output logic [63:0]       enc_value,
  input  logic [39:0]       enc_hdr,
  input  logic [79:0]       enc_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              msg_done,
  output logic [CNT_W-1:0]  msg_len,
  output logic              enc_err
);

  localparam int unsigned HDR_B = 5;
  localparam int unsigned VAL_B = 10;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HDR, S_VAL} state_t;

  state_t             r_state;
  logic [39:0]        r_hdr_sr;
  logic [79:0]        r_val_sr;
  logic [2:0]         r_hdr_cnt;
  logic [3:0]         r_val_cnt;
  logic               r_last;
  logic [CNT_W-1:0]   r_cnt;

  logic [2:0]         w_hdr_len;
  logic [3:0]         w_val_len;
  logic               w_hdr_err;
  logic               w_val_err;
  logic               w_beat;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign req_ready = (r_state == S_IDLE) && !reset;
  assign w_beat    = out_valid && out_ready;
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  // Length = index of the lowest byte without a continuation bit, plus one.
  always_comb begin
    w_hdr_len = 3'(HDR_B);
    w_hdr_err = 1'b1;
    for (int k = int'(HDR_B) - 1; k >= 0; k--) begin
      if (!enc_hdr[8*k+7]) begin
        w_hdr_len = 3'(k + 1);
        w_hdr_err = 1'b0;
      end
    end
    w_val_len = 4'(VAL_B);
    w_val_err = 1'b1;
    for (int k = int'(VAL_B) - 1; k >= 0; k--) begin
      if (!enc_val[8*k+7]) begin
        w_val_len = 4'(k + 1);
        w_val_err = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_hdr_sr       <= '0;
      r_val_sr       <= '0;
      r_hdr_cnt      <= '0;
      r_val_cnt      <= '0;
      r_last         <= 1'b0;
      r_cnt          <= '0;
      enc_field_id   <= '0;
      enc_field_type <= '0;
      enc_value      <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_last       <= 1'b0;
      msg_done       <= 1'b0;
      msg_len        <= '0;
      enc_err        <= 1'b0;
    end else begin
      msg_done <= 1'b0;
      if (w_beat) r_cnt <= w_cnt_inc;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            enc_field_id   <= req_field_id;
            enc_field_type <= req_field_type;
            enc_value      <= req_value;
            r_last         <= req_last;
            r_state        <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_hdr_sr  <= enc_hdr;
          r_val_sr  <= enc_val;
          r_hdr_cnt <= w_hdr_len;
          r_val_cnt <= w_val_len;
          enc_err   <= enc_err | w_hdr_err | w_val_err;
          out_valid <= 1'b1;
          out_data  <= enc_hdr[7:0];
          out_last  <= 1'b0;
          r_state   <= S_HDR;
        end
        S_HDR: begin
          if (w_beat) begin
            if (r_hdr_cnt == 3'd1) begin
              out_data <= r_val_sr[7:0];
              out_last <= r_last && (r_val_cnt == 4'd1);
              r_state  <= S_VAL;
            end else begin
              r_hdr_sr  <= r_hdr_sr >> 8;
              r_hdr_cnt <= r_hdr_cnt - 3'd1;
              out_data  <= r_hdr_sr[15:8];
            end
          end
        end
        S_VAL: begin
          if (w_beat) begin
            if (r_val_cnt == 4'd1) begin
              out_valid <= 1'b0;
              out_data  <= '0;
              out_last  <= 1'b0;
              r_state   <= S_IDLE;
              // Message boundary: publish saturated total and restart the count.
              if (r_last) begin
                msg_len  <= w_cnt_inc;
                r_cnt    <= '0;
                msg_done <= 1'b1;
              end
            end else begin
              r_val_sr  <= r_val_sr >> 8;
              r_val_cnt <= r_val_cnt - 4'd1;
              out_data  <= r_val_sr[15:8];
              out_last  <= r_last && (r_val_cnt == 4'd2);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pb_field_sequencer.sv
// Bench for pb_field_sequencer: behavioural varint encoder stubs plus a
// byte-list reference model, directed cases then randomized fields.
module tb_pb_field_sequencer;

  localparam int unsigned CNT_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [28:0]       req_field_id;
  logic [4:0]        req_field_type;
  logic [63:0]       req_value;
  logic              req_last;
  logic [28:0]       enc_field_id;
  logic [4:0]        enc_field_type;
  logic [63:0]       enc_value;
  logic [39:0]       enc_hdr;
  logic [79:0]       enc_val;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic              out_last;
  logic              msg_done;
  logic [CNT_W-1:0]  msg_len;
  logic              enc_err;

  logic              bad_mode;
  int                n_cmp  = 0;
  int                n_fail = 0;
  int                exp_cnt = 0;
  logic              exp_err = 1'b0;

  always #5 clk = ~clk;

  pb_field_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_field_id(req_field_id), .req_field_type(req_field_type),
    .req_value(req_value), .req_last(req_last),
    .enc_field_id(enc_field_id), .enc_field_type(enc_field_type),
    .enc_value(enc_value), .enc_hdr(enc_hdr), .enc_val(enc_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .msg_done(msg_done), .msg_len(msg_len),
    .enc_err(enc_err)
  );

  // Number of 7-bit groups needed to carry v (at least one).
  function automatic int vlen(input logic [63:0] v);
    int n = 1;
    logic [63:0] t = v >> 7;
    while (t != 0) begin
      n++;
      t = t >> 7;
    end
    return n;
  endfunction

  function automatic logic [79:0] vpack(input logic [63:0] v);
    logic [79:0] r = '0;
    int n = vlen(v);
    for (int k = 0; k < n; k++)
      r[8*k +: 8] = {(k < n - 1) ? 1'b1 : 1'b0, 7'(v >> (7 * k))};
    return r;
  endfunction

  always_comb begin
    enc_hdr = 40'(vpack(64'({enc_field_id, enc_field_type[2:0]})));
    enc_val = bad_mode ? '1 : vpack(enc_value);
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one field; called and returns at a negedge. abort_at>=0 resets at that byte.
  task automatic run_field(input logic [28:0] id, input logic [4:0] ty, input logic [63:0] val,
                           input logic last, input logic bad, input bit rnd_ready,
                           input bit hold, input int abort_at);
    byte unsigned exp[$];
    logic [79:0] hv;
    int n, i, cyc;
    bit rdy;
    hv = vpack(64'({id, ty[2:0]}));
    for (int k = 0; k < vlen(64'({id, ty[2:0]})); k++) exp.push_back(hv[8*k +: 8]);
    if (bad) begin
      for (int k = 0; k < 10; k++) exp.push_back(8'hFF);
    end else begin
      hv = vpack(val);
      for (int k = 0; k < vlen(val); k++) exp.push_back(hv[8*k +: 8]);
    end
    n = exp.size();
    bad_mode = bad;
    req_field_id = id; req_field_type = ty; req_value = val; req_last = last;
    req_valid = 1'b1;
    out_ready = 1'b0;
    check("req_ready_idle", 80'(req_ready), 80'(1));
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      req_field_id = id ^ 29'h1;
      req_value = ~val;
    end else begin
      req_valid = 1'b0;
    end
    check("load_out_valid", 80'(out_valid), 80'(0));
    check("load_req_ready", 80'(req_ready), 80'(0));
    check("load_msg_done", 80'(msg_done), 80'(0));
    check("enc_latched", {enc_field_id, enc_field_type, enc_value}, {id, ty, val});
    @(posedge clk);
    @(negedge clk);
    i = 0; cyc = 0;
    while (i < n && cyc < 400) begin
      rdy = rnd_ready ? bit'($urandom_range(0, 1)) : 1'b1;
      check("out_valid", 80'(out_valid), 80'(1));
      check($sformatf("byte%0d", i), 80'(out_data), 80'(exp[i]));
      check($sformatf("last%0d", i), 80'(out_last), 80'(last && (i == n - 1)));
      check("busy_req_ready", 80'(req_ready), 80'(0));
      check("enc_hold", {enc_field_id, enc_value}, {id, val});
      if (i == abort_at) begin
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b0;
        check("rst_out_valid", 80'(out_valid), 80'(0));
        check("rst_msg_done", 80'(msg_done), 80'(0));
        exp_cnt = 0;
        exp_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_no_done", 80'(msg_done), 80'(0));
        return;
      end
      out_ready = rdy;
      @(posedge clk);
      @(negedge clk);
      if (rdy) i++;
      cyc++;
    end
    if (i < n) begin
      n_cmp++;
      n_fail++;
      $error("FAIL timeout: observed %0d bytes expected %0d", i, n);
    end
    out_ready = 1'b0;
    req_valid = 1'b0;
    exp_cnt += n;
    exp_err |= bad;
    check("end_out_valid", 80'(out_valid), 80'(0));
    check("msg_done", 80'(msg_done), 80'(last));
    if (last) begin
      check("msg_len", 80'(msg_len), 80'(exp_cnt));
      exp_cnt = 0;
    end
    check("end_req_ready", 80'(req_ready), 80'(1));
    check("enc_err", 80'(enc_err), 80'(exp_err));
  endtask

  initial begin
    logic [63:0] rv;
    reset = 1'b1; req_valid = 1'b0; req_field_id = '0; req_field_type = '0;
    req_value = '0; req_last = 1'b0; out_ready = 1'b0; bad_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 80'(req_ready), 80'(0));
    check("rst_outs", 80'({out_valid, out_data, out_last, msg_done, enc_err}), 80'(0));
    check("rst_msg_len", 80'(msg_len), 80'(0));
    check("rst_enc", {enc_field_id, enc_field_type, enc_value}, 98'(0));
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);

    run_field(29'd1, 5'd0, 64'd150, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    run_field(29'd300, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_field(29'd2, 5'd0, 64'd1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    run_field(29'd1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    run_field(29'd3, 5'd0, 64'd5, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    run_field(29'd4, 5'd2, 64'd77, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    run_field(29'd1, 5'd0, 64'd150, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    run_field(29'd5, 5'd0, 64'd300, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    run_field(29'd7, 5'd1, 64'h1234, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    run_field(29'd9, 5'd5, 64'd2, 1'b1, 1'b0, 1'b0, 1'b1, -1);

    for (int f = 0; f < 40; f++) begin
      rv = {$urandom, $urandom} >> $urandom_range(0, 63);
      run_field(29'({$urandom} >> $urandom_range(3, 31)), 5'($urandom_range(0, 31)), rv,
                (f == 39) || ($urandom_range(0, 2) == 0), 1'b0, bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
